// File: rtl/pipe_stage_register.sv
// ---------------------------------------------------------------------------
// pipe_stage_register
//
// Generic elastic pipeline stage with a valid/ready handshake on both sides.
// It carries an opaque payload (no reset) and a control field that is reset
// and masked to CTRL_RST whenever the stage presents no valid entry.
//
// Build option:
//   PIPE_SKID_EN  defined   -> two entries (main + skid). ready_o comes
//                              straight from a flop, so backpressure never
//                              forms a combinational path upstream.
//                 undefined -> single entry. ready_o = !valid_o || ready_i,
//                              which is combinational from ready_i.
//
// Ports:
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   valid_i      in   upstream entry present
//   ready_o      out  stage accepts an entry this cycle
//   data_i       in   [DATA_W] upstream payload
//   ctrl_i       in   [CTRL_W] upstream control field
//   flush_i      in   drop every held entry and the current input
//   valid_o      out  head entry present
//   ready_i      in   downstream accepts this cycle
//   data_o       out  [DATA_W] head payload (holds last value when empty)
//   ctrl_o       out  [CTRL_W] head control, CTRL_RST when valid_o = 0
//   occupancy_o  out  [2] number of held entries
// ---------------------------------------------------------------------------
module pipe_stage_register #(
  parameter int                 DATA_W   = 32,
  parameter int                 CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]  CTRL_RST = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [1:0]        occupancy_o
);

  // Occupancy doubles as the state encoding.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic accept;
  logic emit;
  logic ld_main_in;   // main <- input

  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;

`ifdef PIPE_SKID_EN
  logic              ld_main_skid; // main <- skid (drain from FULL)
  logic              ld_skid;      // skid <- input
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
`endif

  assign accept = valid_i && ready_o;
  assign emit   = valid_o && ready_i;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and load-enable logic. Flush wins over everything: the state
  // empties and no register loads, so a same-cycle input is dropped.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ld_main_in = 1'b0;
`ifdef PIPE_SKID_EN
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
`endif
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            ld_main_in = 1'b1;
            state_d    = ST_BUSY;
          end
        end
        ST_BUSY: begin
`ifdef PIPE_SKID_EN
          if (accept && emit) begin
            ld_main_in = 1'b1;
          end else if (accept) begin
            // Head is stalled; park the newcomer behind it.
            ld_skid = 1'b1;
            state_d = ST_FULL;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
`else
          // With a single entry an accept while busy implies an emit.
          if (accept) begin
            ld_main_in = 1'b1;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
`endif
        end
`ifdef PIPE_SKID_EN
        ST_FULL: begin
          // ready_o is low here, so only the drain can happen.
          if (emit) begin
            ld_main_skid = 1'b1;
            state_d      = ST_BUSY;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    valid_o     = (state_q != ST_EMPTY);
    ctrl_o      = valid_o ? main_ctrl_q : CTRL_RST;
    data_o      = main_data_q;
    occupancy_o = state_q;
`ifdef PIPE_SKID_EN
    ready_o     = ready_q;
`else
    ready_o     = !valid_o || ready_i;
`endif
  end

`ifdef PIPE_SKID_EN
  // ready is precomputed from the next state so it leaves a flop directly.
  assign ready_d = (state_d != ST_FULL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= ready_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Control field: reset so a stale write-enable can never leak after reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_ctrl_q <= CTRL_RST;
    end else if (ld_main_in) begin
      main_ctrl_q <= ctrl_i;
`ifdef PIPE_SKID_EN
    end else if (ld_main_skid) begin
      main_ctrl_q <= skid_ctrl_q;
`endif
    end
  end

`ifdef PIPE_SKID_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_ctrl_q <= CTRL_RST;
    end else if (ld_skid) begin
      skid_ctrl_q <= ctrl_i;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Payload: no reset, loads only on accept or skid transfer.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ld_main_in) begin
      main_data_q <= data_i;
`ifdef PIPE_SKID_EN
    end else if (ld_main_skid) begin
      main_data_q <= skid_data_q;
`endif
    end
  end

`ifdef PIPE_SKID_EN
  always_ff @(posedge clk) begin
    if (ld_skid) begin
      skid_data_q <= data_i;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_register.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_register
//
// Directed self-checking bench for pipe_stage_register. Works with either
// build of the PIPE_SKID_EN option; skid-only scenarios are selected by the
// same macro. Inputs change 1 time unit after a rising edge, outputs are
// sampled 1 time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_register;

  localparam int              DATA_W   = 32;
  localparam int              CTRL_W   = 8;
  localparam logic [CTRL_W-1:0] CTRL_RST = 8'hA5;

  logic              clk;
  logic              reset_n;
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] data_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              flush_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] data_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [1:0]        occupancy_o;

  int checks;
  int failures;

  pipe_stage_register #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CTRL_RST (CTRL_RST)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .ctrl_i      (ctrl_i),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .ctrl_o      (ctrl_o),
    .occupancy_o (occupancy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one cycle and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    valid_i = v;
    data_i  = d;
    ctrl_i  = d[7:0] ^ 8'h40;
  endtask

  task automatic check_empty(input string tag);
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    chk({tag, "_occ"},   {30'd0, occupancy_o}, 32'd0);
    chk({tag, "_ctrl"},  {24'd0, ctrl_o}, {24'd0, CTRL_RST});
  endtask

  task automatic check_head(input string tag, input logic [31:0] d, input logic [1:0] occ);
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
    chk({tag, "_data"},  data_o, d);
    chk({tag, "_ctrl"},  {24'd0, ctrl_o}, {24'd0, d[7:0] ^ 8'h40});
    chk({tag, "_occ"},   {30'd0, occupancy_o}, {30'd0, occ});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    flush_i  = 1'b0;
    ready_i  = 1'b0;
    drive(1'b0, 32'd0);

    // ---- Reset state ----
    #2;
    check_empty("rst");
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    #10 reset_n = 1'b1;
    tick();

    // ---- Streaming 1..8 with ready_i held high ----
    ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i);
      #1;
      chk("stream_ready", {31'd0, ready_o}, 32'd1);
      tick();
      check_head($sformatf("stream%0d", i), i, 2'd1);
    end
    drive(1'b0, 32'hDEAD);
    tick();
    check_empty("stream_end");
    chk("stream_hold_data", data_o, 32'd8);

    // ---- Simultaneous accept and emit while busy ----
    drive(1'b1, 32'h5A);
    tick();
    check_head("ae_first", 32'h5A, 2'd1);
    drive(1'b1, 32'h5B);
    tick();
    check_head("ae_second", 32'h5B, 2'd1);
    drive(1'b0, 32'h0);
    tick();
    check_empty("ae_end");

`ifdef PIPE_SKID_EN
    // ---- Backpressure: fill to FULL, drain in order with no gap ----
    ready_i = 1'b0;
    drive(1'b1, 32'h11);
    tick();
    check_head("bp_a", 32'h11, 2'd1);
    chk("bp_a_ready", {31'd0, ready_o}, 32'd1);
    drive(1'b1, 32'h22);
    tick();
    check_head("bp_full", 32'h11, 2'd2);
    chk("bp_full_ready", {31'd0, ready_o}, 32'd0);
    drive(1'b1, 32'h33);
    tick();
    check_head("bp_held", 32'h11, 2'd2);
    chk("bp_held_ready", {31'd0, ready_o}, 32'd0);
    ready_i = 1'b1;
    tick();
    check_head("bp_b", 32'h22, 2'd1);
    chk("bp_b_ready", {31'd0, ready_o}, 32'd1);
    tick();
    check_head("bp_c", 32'h33, 2'd1);
    drive(1'b0, 32'h0);
    tick();
    check_empty("bp_end");

    // ---- Flush while FULL with an input handshaking ----
    ready_i = 1'b0;
    drive(1'b1, 32'h44);
    tick();
    drive(1'b1, 32'h55);
    tick();
    chk("fl_pre_occ", {30'd0, occupancy_o}, 32'd2);
    ready_i = 1'b1;
    flush_i = 1'b1;
    drive(1'b1, 32'h66);
    tick();
    flush_i = 1'b0;
    drive(1'b0, 32'h0);
    check_empty("flush");
    chk("flush_ready", {31'd0, ready_o}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_stay_empty", {31'd0, valid_o}, 32'd0);
    end

    // ---- Reset mid-stream while FULL ----
    ready_i = 1'b0;
    drive(1'b1, 32'h77);
    tick();
    drive(1'b1, 32'h78);
    tick();
    chk("mrst_pre_occ", {30'd0, occupancy_o}, 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check_empty("mrst");
    chk("mrst_ready", {31'd0, ready_o}, 32'd1);
`else
    // ---- Single entry: ready_o follows ready_i combinationally ----
    ready_i = 1'b0;
    drive(1'b1, 32'h11);
    tick();
    check_head("ss_a", 32'h11, 2'd1);
    drive(1'b1, 32'h22);
    #1;
    chk("ss_ready_lo", {31'd0, ready_o}, 32'd0);
    tick();
    check_head("ss_stall", 32'h11, 2'd1);
    ready_i = 1'b1;
    #1;
    chk("ss_ready_hi", {31'd0, ready_o}, 32'd1);
    tick();
    check_head("ss_b", 32'h22, 2'd1);
    drive(1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      ready_i = k[0];
      #1;
      chk("ss_follow", {31'd0, ready_o}, {31'd0, ready_i});
      chk("ss_occ_le1", {31'd0, occupancy_o <= 2'd1}, 32'd1);
    end
    ready_i = 1'b0;
    tick();
    ready_i = 1'b1;
    tick();
    check_empty("ss_end");

    // ---- Flush while busy with an input handshaking ----
    ready_i = 1'b0;
    drive(1'b1, 32'h44);
    tick();
    ready_i = 1'b1;
    flush_i = 1'b1;
    drive(1'b1, 32'h66);
    tick();
    flush_i = 1'b0;
    drive(1'b0, 32'h0);
    check_empty("flush");
    chk("flush_ready", {31'd0, ready_o}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_stay_empty", {31'd0, valid_o}, 32'd0);
    end

    // ---- Reset mid-stream while busy ----
    ready_i = 1'b0;
    drive(1'b1, 32'h77);
    tick();
    chk("mrst_pre_occ", {30'd0, occupancy_o}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_empty("mrst");
    chk("mrst_ready", {31'd0, ready_o}, 32'd1);
`endif

    drive(1'b0, 32'h0);
    #10 reset_n = 1'b1;
    tick();
    check_empty("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
